// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between two writeback
//   sources: source 0 is ALU/execute, source 1 is load/memory. Each source
//   has a valid/ready handshake. An accepted write is registered and shown
//   on the regfile write port for exactly one cycle. Writes to x0 are
//   accepted and counted, but they never reach the regfile.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   flush                    synchronous pipeline flush; blocks acceptance
//   s0_valid/addr/data       source 0 request      s0_ready  combinational accept
//   s1_valid/addr/data       source 1 request      s1_ready  combinational accept
//   write_ena/write_reg_addr/data_in   registered regfile write port
//   last_grant               source granted most recently
//   x0_drop_cnt              saturating count of discarded x0 writes
module regfile_wb_arbiter #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              s0_valid,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [DATA_W-1:0] s0_data,
   output logic              s0_ready,
   input  logic              s1_valid,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [DATA_W-1:0] s1_data,
   output logic              s1_ready,
   output logic              write_ena,
   output logic [ADDR_W-1:0] write_reg_addr,
   output logic [DATA_W-1:0] data_in,
   output logic              last_grant,
   output logic [7:0]        x0_drop_cnt
);

   localparam bit FIXED_PRIO = (PRIO_MODE == 1);

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_acc;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   // On contention round-robin favours the source that did not win last;
   // fixed priority always favours source 0.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (s0_valid && s1_valid) begin
         if (FIXED_PRIO || last_grant) w_gnt0 = 1'b1;
         else                          w_gnt1 = 1'b1;
      end else begin
         w_gnt0 = s0_valid;
         w_gnt1 = s1_valid;
      end
   end

   // The regfile takes a write every cycle, so only reset and flush gate ready.
   assign s0_ready = w_gnt0 & ~flush & ~rst;
   assign s1_ready = w_gnt1 & ~flush & ~rst;
   assign w_acc    = s0_ready | s1_ready;
   assign w_addr   = s1_ready ? s1_addr : s0_addr;
   assign w_data   = s1_ready ? s1_data : s0_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_ena      <= 1'b0;
         write_reg_addr <= '0;
         data_in        <= '0;
         last_grant     <= 1'b1;
         x0_drop_cnt    <= 8'd0;
      end else if (flush) begin
         write_ena  <= 1'b0;
         last_grant <= 1'b1;
      end else if (w_acc) begin
         last_grant <= s1_ready;
         if (w_addr == '0) begin
            // x0 write: consume it and keep the port's previous address/data.
            write_ena <= 1'b0;
            if (x0_drop_cnt != 8'hff) x0_drop_cnt <= x0_drop_cnt + 8'd1;
         end else begin
            write_ena      <= 1'b1;
            write_reg_addr <= w_addr;
            data_in        <= w_data;
         end
      end else begin
         write_ena <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        s0_valid, s1_valid;
   logic [4:0]  s0_addr, s1_addr;
   logic [31:0] s0_data, s1_data;

   logic        rdy0 [2];
   logic        rdy1 [2];
   logic        we   [2];
   logic [4:0]  wa   [2];
   logic [31:0] wd   [2];
   logic        lg   [2];
   logic [7:0]  cnt  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .PRIO_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(rdy0[0]),
      .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(rdy1[0]),
      .write_ena(we[0]), .write_reg_addr(wa[0]), .data_in(wd[0]),
      .last_grant(lg[0]), .x0_drop_cnt(cnt[0]));

   regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .PRIO_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush),
      .s0_valid(s0_valid), .s0_addr(s0_addr), .s0_data(s0_data), .s0_ready(rdy0[1]),
      .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_data(s1_data), .s1_ready(rdy1[1]),
      .write_ena(we[1]), .write_reg_addr(wa[1]), .data_in(wd[1]),
      .last_grant(lg[1]), .x0_drop_cnt(cnt[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state per instance (index = PRIO_MODE).
   logic        m_lg  [2];
   logic        m_we  [2];
   logic [4:0]  m_wa  [2];
   logic [31:0] m_wd  [2];
   int          m_cnt [2];

   // Which source wins this cycle: -1 none, 0 or 1.
   function automatic int winner(input int m);
      if (!s0_valid && !s1_valid) return -1;
      if (s0_valid && !s1_valid)  return 0;
      if (!s0_valid && s1_valid)  return 1;
      if (m == 1) return 0;
      return m_lg[m] ? 0 : 1;
   endfunction

   function automatic logic exp_rdy(input int m, input int s);
      return !rst && !flush && (winner(m) == s);
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_lg[m] <= 1'b1; m_we[m] <= 1'b0; m_wa[m] <= '0; m_wd[m] <= '0; m_cnt[m] <= 0;
         end else if (flush) begin
            m_we[m] <= 1'b0; m_lg[m] <= 1'b1;
         end else if (winner(m) < 0) begin
            m_we[m] <= 1'b0;
         end else begin
            m_lg[m] <= (winner(m) == 1);
            if (((winner(m) == 1) ? s1_addr : s0_addr) == 5'd0) begin
               m_we[m] <= 1'b0;
               m_cnt[m] <= (m_cnt[m] < 255) ? m_cnt[m] + 1 : 255;
            end else begin
               m_we[m] <= 1'b1;
               m_wa[m] <= (winner(m) == 1) ? s1_addr : s0_addr;
               m_wd[m] <= (winner(m) == 1) ? s1_data : s0_data;
            end
         end
      end
   end

   // Compare process: every cycle, mid-period, both instances.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("m%0d s0_ready", m), 32'(rdy0[m]), 32'(exp_rdy(m, 0)));
         chk($sformatf("m%0d s1_ready", m), 32'(rdy1[m]), 32'(exp_rdy(m, 1)));
         chk($sformatf("m%0d write_ena", m), 32'(we[m]), 32'(m_we[m]));
         chk($sformatf("m%0d write_reg_addr", m), 32'(wa[m]), 32'(m_wa[m]));
         chk($sformatf("m%0d data_in", m), wd[m], m_wd[m]);
         chk($sformatf("m%0d last_grant", m), 32'(lg[m]), 32'(m_lg[m]));
         chk($sformatf("m%0d x0_drop_cnt", m), 32'(cnt[m]), 32'(m_cnt[m]));
      end
   end

   // Regfile image built from the round-robin instance's write port.
   logic [31:0] rf [32];
   always @(posedge clk or posedge rst) begin
      if (rst) for (int i = 0; i < 32; i++) rf[i] <= '0;
      else if (we[0]) rf[wa[0]] <= wd[0];
   end
   function automatic logic [31:0] rf_rd(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : rf[a];
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      s0_valid = 1'b0; s1_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h5;
      s1_valid = 1'b1; s1_addr = 5'd6; s1_data = 32'h6;
      tick(); tick();
      chk("reset s0_ready", 32'(rdy0[0]), 0);
      chk("reset s1_ready", 32'(rdy1[0]), 0);
      chk("reset write_ena", 32'(we[0]), 0);
      chk("reset last_grant", 32'(lg[0]), 1);
      chk("reset x0_drop_cnt", 32'(cnt[0]), 0);
      rst = 1'b0; idle();
      tick();

      // Round-robin contention; sources drop valid once accepted.
      s0_valid = 1'b1; s0_addr = 5'd2; s0_data = 32'h0ff1ce11;
      s1_valid = 1'b1; s1_addr = 5'd3; s1_data = 32'h00001111;
      #1 chk("rr first s0_ready", 32'(rdy0[0]), 1);
      chk("rr first s1_ready", 32'(rdy1[0]), 0);
      tick(); s0_valid = 1'b0;
      #1 chk("rr second s1_ready", 32'(rdy1[0]), 1);
      chk("rr wr0 addr", 32'(wa[0]), 2);
      tick(); s1_valid = 1'b0;
      #1 chk("rr wr1 ena", 32'(we[0]), 1);
      chk("rr wr1 addr", 32'(wa[0]), 3);
      chk("rr wr1 data", wd[0], 32'h00001111);
      chk("rr last_grant", 32'(lg[0]), 1);
      tick();
      chk("rf x2", rf_rd(5'd2), 32'h0ff1ce11);
      chk("rf x3", rf_rd(5'd3), 32'h00001111);

      // Single source.
      s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h0114beef;
      #1 chk("single s0_ready", 32'(rdy0[0]), 1);
      tick(); s0_valid = 1'b0;
      #1 chk("single ena", 32'(we[0]), 1);
      chk("single addr", 32'(wa[0]), 1);
      chk("single data", wd[0], 32'h0114beef);
      tick();
      chk("single ena drops", 32'(we[0]), 0);

      // x0 drop.
      s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h01111111;
      #1 chk("x0 s1_ready", 32'(rdy1[0]), 1);
      tick(); s1_valid = 1'b0;
      #1 chk("x0 ena", 32'(we[0]), 0);
      chk("x0 cnt", 32'(cnt[0]), 1);
      chk("x0 addr held", 32'(wa[0]), 1);
      chk("x0 data held", wd[0], 32'h0114beef);
      chk("x0 read", rf_rd(5'd0), 0);
      tick();

      // Fixed priority: s1 waits while s0 has three back-to-back requests.
      s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'h44;
      for (int i = 0; i < 3; i++) begin
         s0_valid = 1'b1; s0_addr = 5'(5 + i); s0_data = 32'h50 + i;
         #1 chk("prio s1_ready held", 32'(rdy1[1]), 0);
         chk("prio s0_ready", 32'(rdy0[1]), 1);
         tick();
      end
      s0_valid = 1'b0;
      #1 chk("prio s1 granted", 32'(rdy1[1]), 1);
      chk("prio last s0 write", 32'(wa[1]), 7);
      tick(); s1_valid = 1'b0;
      tick();

      // Flush: write accepted the cycle before still completes.
      s0_valid = 1'b1; s0_addr = 5'd8; s0_data = 32'h88;
      tick();
      flush = 1'b1;
      s0_valid = 1'b1; s0_addr = 5'd9;  s0_data = 32'h99;
      s1_valid = 1'b1; s1_addr = 5'd10; s1_data = 32'haa;
      #1 chk("flush ena", 32'(we[0]), 1);
      chk("flush addr", 32'(wa[0]), 8);
      chk("flush s0_ready", 32'(rdy0[0]), 0);
      chk("flush s1_ready", 32'(rdy1[0]), 0);
      tick(); flush = 1'b0; idle();
      #1 chk("post flush ena", 32'(we[0]), 0);
      chk("post flush last_grant", 32'(lg[0]), 1);
      tick();

      // Reset between edges clears the output stage immediately.
      s0_valid = 1'b1; s0_addr = 5'd11; s0_data = 32'hbb;
      tick(); idle();
      #1 chk("pre rst ena", 32'(we[0]), 1);
      rst = 1'b1;
      #1 chk("async rst ena", 32'(we[0]), 0);
      chk("async rst addr", 32'(wa[0]), 0);
      chk("async rst data", wd[0], 0);
      tick(); rst = 1'b0;
      tick();

      // x0 counter saturation.
      s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1;
      for (int i = 0; i < 260; i++) tick();
      idle();
      #1 chk("x0 cnt saturates", 32'(cnt[0]), 255);
      chk("x0 cnt saturates prio", 32'(cnt[1]), 255);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
